// File: rtl/sha3_miner_csr.sv
// -----------------------------------------------------------------------------
// sha3_miner_csr
//
// Avalon-MM control/status slave that configures and sequences the
// sha3_256_miner engine from the HPS lightweight bridge. It holds the header,
// difficulty, start nonce and pad configuration. It walks the miner through a
// run-low drop window before each (re)start, captures the reported solution
// on the rising edge of m_irq, and raises a maskable, registered interrupt.
//
// Optional feature macro: SHA3_MINER_CSR_CYCLE_CNT_EN
//   Defined   : 64-bit RUN-cycle counter with hi shadow at word addresses 24/25.
//   Undefined : no counter logic; addresses 24/25 read 0.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   avs_address     : word address (5 bits)
//   avs_read        : read strobe; avs_readdata valid the following cycle
//   avs_write       : write strobe; takes effect the following cycle
//   avs_writedata   : write data
//   avs_readdata    : registered read data
//   avs_irq         : interrupt to HPS (irq_status & irq_enable, registered)
//   m_header        : 256-bit header to miner
//   m_difficulty    : 256-bit difficulty to miner
//   m_start_nonce   : 64-bit start nonce to miner
//   m_control       : {padf[7:0], padl[7:0], halt, test, run} to miner
//   m_solution      : solution nonce from miner
//   m_status        : miner status, mirrored in STATUS[6:0]
//   m_irq           : miner "found" flag; its rising edge is the capture event
//   m_bsy           : miner busy, mirrored in STATUS[9]
//
// Bus handshake: Avalon-MM without waitrequest. A cycle with avs_write high is
// one accepted write; a cycle with avs_read high is one accepted read whose
// data is presented on avs_readdata exactly one cycle later and held until the
// next read. Strobes are never stalled.
//
// The FSM state is visible to software and checkers through STATUS[8:7].
// -----------------------------------------------------------------------------
module sha3_miner_csr #(
    // Run-low window before a (re)start; at least 3 so the miner's two-flop
    // control synchronizer sees run low long enough to reset itself.
    parameter int DROP_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic         avs_irq,
    output logic [255:0] m_header,
    output logic [255:0] m_difficulty,
    output logic [63:0]  m_start_nonce,
    output logic [18:0]  m_control,
    input  logic [63:0]  m_solution,
    input  logic [6:0]   m_status,
    input  logic         m_irq,
    input  logic         m_bsy
);

    localparam int CNT_W = $clog2(DROP_CYCLES + 1);

    localparam logic [4:0] A_NONCE_LO = 5'd16;
    localparam logic [4:0] A_NONCE_HI = 5'd17;
    localparam logic [4:0] A_CONFIG   = 5'd18;
    localparam logic [4:0] A_CMD      = 5'd19;
    localparam logic [4:0] A_STATUS   = 5'd20;
    localparam logic [4:0] A_SOL_LO   = 5'd21;
    localparam logic [4:0] A_SOL_HI   = 5'd22;
    localparam logic [4:0] A_IRQ      = 5'd23;
`ifdef SHA3_MINER_CSR_CYCLE_CNT_EN
    localparam logic [4:0] A_CYC_LO   = 5'd24;
    localparam logic [4:0] A_CYC_HI   = 5'd25;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DROP = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] drop_cnt_q;

    logic [255:0] header_q;
    logic [255:0] difficulty_q;
    logic [63:0]  nonce_q;
    logic [16:0]  config_q;        // [0] test, [8:1] padl, [16:9] padf

    logic         halt_q;
    logic         halted_q;
    logic         irq_status_q;
    logic         irq_enable_q;
    logic         m_irq_d;
    logic         avs_irq_q;
    logic [63:0]  solution_q;
    logic [31:0]  sol_hi_shadow_q;
    logic [31:0]  rdata_q;
    logic [31:0]  rd_data;

    // Bus decode
    logic wr_cmd;
    logic cmd_start;
    logic cmd_stop;
    logic cmd_halt;
    logic wr_w1c;
    logic capture;
    logic cfg_wr_ok;

    // FSM side effects
    logic drop_load;
    logic do_capture;
    logic irq_clear;
    logic halt_set;

    assign wr_cmd = avs_write && (avs_address == A_CMD);

    // One command per write: stop beats start beats halt.
    assign cmd_stop  = wr_cmd && avs_writedata[1];
    assign cmd_start = wr_cmd && avs_writedata[0] && !avs_writedata[1];
    assign cmd_halt  = wr_cmd && avs_writedata[2] && !avs_writedata[1] && !avs_writedata[0];

    assign wr_w1c  = avs_write && (avs_address == A_IRQ) && avs_writedata[1];
    assign capture = m_irq && !m_irq_d;

    // Miner-facing configuration may only change while the miner is not
    // actively hashing (IDLE) or is frozen on a result (DONE).
    assign cfg_wr_ok = (state_q == S_IDLE) || (state_q == S_DONE);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_n;
            if (drop_load) begin
                drop_cnt_q <= CNT_W'(DROP_CYCLES - 1);
            end else if (state_q == S_DROP && drop_cnt_q != '0) begin
                drop_cnt_q <= drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n    = state_q;
        drop_load  = 1'b0;
        do_capture = 1'b0;
        irq_clear  = 1'b0;
        halt_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    state_n   = S_DROP;
                    drop_load = 1'b1;
                end
            end
            S_DROP: begin
                if (cmd_stop) begin
                    state_n = S_IDLE;
                end else if (cmd_start) begin
                    drop_load = 1'b1;
                end else if (drop_cnt_q == '0) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                // A stop or restart in the capture cycle discards the result.
                if (cmd_stop) begin
                    state_n = S_IDLE;
                end else if (cmd_start) begin
                    state_n   = S_DROP;
                    drop_load = 1'b1;
                end else if (capture) begin
                    state_n    = S_DONE;
                    do_capture = 1'b1;
                end else if (cmd_halt) begin
                    halt_set = 1'b1;
                end
            end
            S_DONE: begin
                // run and halt stay as they were so the miner holds its result.
                if (cmd_start) begin
                    state_n   = S_DROP;
                    drop_load = 1'b1;
                    irq_clear = 1'b1;
                end else if (wr_w1c) begin
                    state_n   = S_IDLE;
                    irq_clear = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Configuration registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            header_q     <= '0;
            difficulty_q <= '0;
            nonce_q      <= '0;
            config_q     <= '0;
        end else if (avs_write && cfg_wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (avs_address == 5'(i))     header_q[i*32 +: 32]     <= avs_writedata;
                if (avs_address == 5'(i + 8)) difficulty_q[i*32 +: 32] <= avs_writedata;
            end
            if (avs_address == A_NONCE_LO) nonce_q[31:0]  <= avs_writedata;
            if (avs_address == A_NONCE_HI) nonce_q[63:32] <= avs_writedata;
            if (avs_address == A_CONFIG)   config_q       <= avs_writedata[16:0];
        end
    end

    // -------------------------------------------------------------------------
    // Halt, capture and interrupt
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q       <= 1'b0;
            halted_q     <= 1'b0;
            irq_status_q <= 1'b0;
            irq_enable_q <= 1'b0;
            m_irq_d      <= 1'b0;
            avs_irq_q    <= 1'b0;
            solution_q   <= '0;
        end else begin
            m_irq_d   <= m_irq;
            avs_irq_q <= irq_status_q && irq_enable_q;

            // Halt is dropped whenever the miner is sent back through run-low.
            if (state_n == S_IDLE || state_n == S_DROP) begin
                halt_q <= 1'b0;
            end else if (halt_set) begin
                halt_q <= 1'b1;
            end

            if (do_capture) begin
                solution_q   <= m_solution;
                halted_q     <= halt_q;
                irq_status_q <= 1'b1;
            end else if (irq_clear) begin
                irq_status_q <= 1'b0;
            end

            if (avs_write && avs_address == A_IRQ) begin
                irq_enable_q <= avs_writedata[0];
            end
        end
    end

    // Reading the solution lo half freezes the hi half for the following read.
    always_ff @(posedge clk) begin
        if (rst) begin
            sol_hi_shadow_q <= '0;
        end else if (avs_read && avs_address == A_SOL_LO) begin
            sol_hi_shadow_q <= solution_q[63:32];
        end
    end

`ifdef SHA3_MINER_CSR_CYCLE_CNT_EN
    // -------------------------------------------------------------------------
    // RUN-cycle counter
    // -------------------------------------------------------------------------
    logic [63:0] cyc_q;
    logic [31:0] cyc_hi_shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q           <= '0;
            cyc_hi_shadow_q <= '0;
        end else begin
            if (drop_load) begin
                cyc_q <= '0;
            end else if (state_q == S_RUN) begin
                cyc_q <= cyc_q + 64'd1;
            end
            if (avs_read && avs_address == A_CYC_LO) begin
                cyc_hi_shadow_q <= cyc_q[63:32];
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Read path
    // -------------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (avs_address[4:3] == 2'b00) begin
            rd_data = header_q[{avs_address[2:0], 5'd0} +: 32];
        end else if (avs_address[4:3] == 2'b01) begin
            rd_data = difficulty_q[{avs_address[2:0], 5'd0} +: 32];
        end else begin
            case (avs_address)
                A_NONCE_LO: rd_data = nonce_q[31:0];
                A_NONCE_HI: rd_data = nonce_q[63:32];
                A_CONFIG:   rd_data = {15'd0, config_q};
                A_STATUS:   rd_data = {19'd0, halted_q, irq_enable_q, irq_status_q,
                                       m_bsy, state_q, m_status};
                A_SOL_LO:   rd_data = solution_q[31:0];
                A_SOL_HI:   rd_data = sol_hi_shadow_q;
                A_IRQ:      rd_data = {30'd0, irq_status_q, irq_enable_q};
`ifdef SHA3_MINER_CSR_CYCLE_CNT_EN
                A_CYC_LO:   rd_data = cyc_q[31:0];
                A_CYC_HI:   rd_data = cyc_hi_shadow_q;
`endif
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (avs_read) begin
            rdata_q <= rd_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign avs_readdata  = rdata_q;
    assign avs_irq       = avs_irq_q;
    assign m_header      = header_q;
    assign m_difficulty  = difficulty_q;
    assign m_start_nonce = nonce_q;
    assign m_control     = {config_q[16:9], config_q[8:1], halt_q, config_q[0],
                            (state_q == S_RUN) || (state_q == S_DONE)};

endmodule
